key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion.sv | 111 +++++++++++
 tb/tb_key_expansion.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake,
// producing one new round key per accepted transfer.
module key_expansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         done
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    logic [0:0]   state;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t, nw0, nw1, nw2, nw3;
    logic [127:0] next_key;
    logic         transfer;
    logic         last;

    always_comb begin
        w0 = round_key[127:96];
        w1 = round_key[95:64];
        w2 = round_key[63:32];
        w3 = round_key[31:0];
        t   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        nw0 = w0 ^ t;
        nw1 = w1 ^ nw0;
        nw2 = w2 ^ nw1;
        nw3 = w3 ^ nw2;
        next_key  = {nw0, nw1, nw2, nw3};
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        transfer  = rk_valid & rk_ready;
        last      = (rk_idx == 4'(NR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            rk_idx    <= '0;
            round_key <= '0;
            rcon      <= 8'h01;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= cipher_key;
                        rk_idx    <= '0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        rcon      <= 8'h01;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    // Final key keeps its value and index after hand-off.
                    if (transfer) begin
                        if (last) begin
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            round_key <= next_key;
                            rk_idx    <= rk_idx + 4'd1;
                            rcon      <= rcon_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion against a FIPS-197 word-recurrence model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_key_expansion;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got [11];
    int           cycles;

    key_expansion #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .round_key  (round_key),
        .rk_idx     (rk_idx),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [134:0] status();
        return {rk_valid, busy, done, rk_idx, round_key};
    endfunction

    task automatic check(input string tag, input logic [134:0] obs, input logic [134:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one expansion; pre means start was already driven in the current cycle.
    task automatic run_key(input logic [127:0] key, input int unsigned ready_pct,
                           input bit pre, input int restart_at, input int abort_at,
                           input bit chain, input logic [127:0] chain_key);
        int n = 0;
        bit finished = 0;
        bit aborted  = 0;
        bit restarted = 0;
        model(key);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1; cipher_key = key; rk_ready = 1'b0;
        end
        @(negedge clk);
        start = 1'b0; cipher_key = rand_key();
        cycles = 0;
        for (int i = 0; i < 400 && !finished && !aborted; i++) begin
            cycles++;
            check($sformatf("rk%0d", n), status(), {3'b110, 4'(n), exp_rk[n]});
            got[n] = round_key;
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check("async_reset", status(), '0);
                @(negedge clk);
                check("reset_hold", status(), '0);
                rst_n = 1'b1;
                @(negedge clk);
                check("reset_release", status(), '0);
                aborted = 1;
            end else begin
                start = (n == restart_at) && !restarted;
                if (start) begin cipher_key = rand_key(); restarted = 1; end
                rk_ready = ($urandom_range(1, 100) <= ready_pct);
                if (rk_ready) begin
                    if (n == 10) finished = 1;
                    else n++;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        rk_ready = 1'b0;
        if (!aborted) begin
            check("finished", 135'(finished), 135'(1));
            check("done", status(), {3'b001, 4'd10, exp_rk[10]});
            if (chain) begin
                start = 1'b1; cipher_key = chain_key;
            end else begin
                @(negedge clk);
                check("idle", status(), {3'b000, 4'd10, exp_rk[10]});
            end
        end
    endtask

    initial begin
        logic [127:0] k2;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; cipher_key = '0;
        build_sbox();
        @(negedge clk);
        check("reset_state", status(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_release", status(), '0);

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 0, 99, 99, 0, '0);
        check("fips_rk0", 135'(got[0]), 135'(128'h2b7e151628aed2a6abf7158809cf4f3c));
        check("fips_rk1", 135'(got[1]), 135'(128'ha0fafe1788542cb123a339392a6c7605));
        check("fips_rk10", 135'(got[10]), 135'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("valid_cycles", 135'(cycles), 135'(11));

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 50, 0, 99, 99, 0, '0);
        check("stall_rk10", 135'(got[10]), 135'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 0, 4, 99, 0, '0);
        check("restart_rk10", 135'(got[10]), 135'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 0, 99, 6, 0, '0);
        run_key(128'h000102030405060708090a0b0c0d0e0f, 70, 0, 99, 99, 0, '0);
        check("post_reset_rk10", 135'(got[10]), 135'(128'h13111d7fe3944a17f307a78b4d2b30c5));

        k2 = rand_key();
        run_key(rand_key(), 100, 0, 99, 99, 1, k2);
        run_key(k2, 100, 1, 99, 99, 0, '0);

        for (int i = 0; i < 1000; i++)
            run_key(rand_key(), $urandom_range(30, 100), 0, 99, 99, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
